// File: rtl/instrumented_adder_sequencer_if.sv
// Request/result and adder-control bundle between the host registers, the
// measurement sequencer and the wrapped instrumented adder.
interface instrumented_adder_sequencer_if #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 5,
    parameter int WIN_W = 16,
    parameter int CNT_W = 32,
    parameter int ACC_W = 40
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [SEL_W-1:0] req_ring_bit;
    logic [SEL_W-1:0] req_ext_bit;
    logic [SEL_W-1:0] req_s_bit;
    logic [WIN_W-1:0] req_window;
    logic [7:0]       req_repeats;
    logic             busy;
    logic             done;
    logic             aborted;
    logic             overflow;
    logic [ACC_W-1:0] result_sum;
    logic [CNT_W-1:0] result_last;
    logic [WIDTH-1:0] a_input;
    logic [WIDTH-1:0] b_input;
    logic [WIDTH-1:0] a_input_ring_bit_b;
    logic [WIDTH-1:0] a_input_ext_bit_b;
    logic [WIDTH-1:0] s_output_bit_b;
    logic             ring_en;
    logic             counter_en;
    logic             counter_rst;
    logic [CNT_W-1:0] ring_count;

    modport master (
        output start, abort, req_a, req_b, req_ring_bit, req_ext_bit, req_s_bit,
               req_window, req_repeats, ring_count,
        input  busy, done, aborted, overflow, result_sum, result_last, a_input, b_input,
               a_input_ring_bit_b, a_input_ext_bit_b, s_output_bit_b,
               ring_en, counter_en, counter_rst
    );

    modport slave (
        input  start, abort, req_a, req_b, req_ring_bit, req_ext_bit, req_s_bit,
               req_window, req_repeats, ring_count,
        output busy, done, aborted, overflow, result_sum, result_last, a_input, b_input,
               a_input_ring_bit_b, a_input_ext_bit_b, s_output_bit_b,
               ring_en, counter_en, counter_rst
    );
endinterface

// File: rtl/instrumented_adder_sequencer.sv
// Sequences one ring-oscillator measurement request through LOAD/ARM/RUN/SETTLE/CAPTURE
// for the requested number of repeats and accumulates the captured ring counts.
module instrumented_adder_sequencer #(
    parameter int WIDTH         = 32,
    parameter int SEL_W         = 5,
    parameter int WIN_W         = 16,
    parameter int CNT_W         = 32,
    parameter int ACC_W         = 40,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_i,
    instrumented_adder_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ARM, S_RUN, S_SETTLE, S_CAPTURE, S_DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [WIN_W-1:0] timer_reg, timer_next;
    logic [7:0]       remaining_reg, remaining_next;

    logic [WIDTH-1:0] a_reg, b_reg;
    logic [SEL_W-1:0] ring_bit_reg, ext_bit_reg, s_bit_reg;
    logic [WIN_W-1:0] window_reg;

    logic             busy_reg, done_reg, aborted_reg, overflow_reg;
    logic             ring_en_reg, counter_en_reg, counter_rst_reg;
    logic [ACC_W-1:0] result_sum_reg;
    logic [CNT_W-1:0] result_last_reg;
    logic [WIDTH-1:0] a_input_reg, b_input_reg;
    logic [WIDTH-1:0] ring_sel_reg, ext_sel_reg, s_sel_reg;

    logic             accept, capture;
    logic [SEL_W-1:0] ring_idx, ext_idx, s_idx;
    logic [WIDTH-1:0] ring_sel, ext_sel, s_sel;
    logic [ACC_W:0]   sum_ext;

    assign accept  = (state_reg == S_IDLE) && bus.start;
    assign capture = (state_reg == S_CAPTURE) && !bus.abort;

    // The first LOAD follows the accepting edge directly, so it takes the request fields
    // straight from the bus; later iterations reuse the registered copies.
    assign ring_idx = accept ? bus.req_ring_bit : ring_bit_reg;
    assign ext_idx  = accept ? bus.req_ext_bit  : ext_bit_reg;
    assign s_idx    = accept ? bus.req_s_bit    : s_bit_reg;

    // Active-low one-hot decode; an index beyond the bus matches no bit and selects nothing.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_sel
            assign ring_sel[gi] = (ring_idx != SEL_W'(gi));
            assign ext_sel[gi]  = (ext_idx  != SEL_W'(gi));
            assign s_sel[gi]    = (s_idx    != SEL_W'(gi));
        end
    endgenerate

    assign sum_ext = {1'b0, result_sum_reg} + {{(ACC_W + 1 - CNT_W){1'b0}}, bus.ring_count};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg     <= S_IDLE;
            timer_reg     <= '0;
            remaining_reg <= '0;
        end else begin
            state_reg     <= state_next;
            timer_reg     <= timer_next;
            remaining_reg <= remaining_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        timer_next     = timer_reg;
        remaining_next = remaining_reg;
        case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    state_next     = S_LOAD;
                    remaining_next = (bus.req_repeats == 8'd0) ? 8'd1 : bus.req_repeats;
                end
            end
            S_LOAD: state_next = S_ARM;
            S_ARM: begin
                state_next = S_RUN;
                timer_next = window_reg - WIN_W'(1);
            end
            S_RUN: begin
                if (timer_reg == '0) begin
                    state_next = S_SETTLE;
                    timer_next = WIN_W'(SETTLE_CYCLES - 1);
                end else begin
                    timer_next = timer_reg - WIN_W'(1);
                end
            end
            S_SETTLE: begin
                if (timer_reg == '0) state_next = S_CAPTURE;
                else                 timer_next = timer_reg - WIN_W'(1);
            end
            S_CAPTURE: begin
                remaining_next = remaining_reg - 8'd1;
                state_next     = (remaining_reg == 8'd1) ? S_DONE : S_LOAD;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (bus.abort && (state_reg != S_IDLE)) state_next = S_IDLE;
    end

    // Outputs are decoded from the next state so each one is registered yet lines up
    // with the cycle its state is occupied.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            a_reg           <= '0;
            b_reg           <= '0;
            ring_bit_reg    <= '0;
            ext_bit_reg     <= '0;
            s_bit_reg       <= '0;
            window_reg      <= '0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            aborted_reg     <= 1'b0;
            overflow_reg    <= 1'b0;
            ring_en_reg     <= 1'b0;
            counter_en_reg  <= 1'b0;
            counter_rst_reg <= 1'b0;
            result_sum_reg  <= '0;
            result_last_reg <= '0;
            a_input_reg     <= '0;
            b_input_reg     <= '0;
            ring_sel_reg    <= '1;
            ext_sel_reg     <= '1;
            s_sel_reg       <= '1;
        end else begin
            if (accept) begin
                a_reg           <= bus.req_a;
                b_reg           <= bus.req_b;
                ring_bit_reg    <= bus.req_ring_bit;
                ext_bit_reg     <= bus.req_ext_bit;
                s_bit_reg       <= bus.req_s_bit;
                window_reg      <= (bus.req_window == '0) ? WIN_W'(1) : bus.req_window;
                result_sum_reg  <= '0;
                result_last_reg <= '0;
                overflow_reg    <= 1'b0;
            end
            if (capture) begin
                result_last_reg <= bus.ring_count;
                result_sum_reg  <= sum_ext[ACC_W-1:0];
                if (sum_ext[ACC_W]) overflow_reg <= 1'b1;
            end
            if (state_next == S_LOAD) begin
                a_input_reg  <= accept ? bus.req_a : a_reg;
                b_input_reg  <= accept ? bus.req_b : b_reg;
                ring_sel_reg <= ring_sel;
                ext_sel_reg  <= ext_sel;
                s_sel_reg    <= s_sel;
            end
            busy_reg        <= (state_next != S_IDLE);
            done_reg        <= (state_next == S_DONE);
            aborted_reg     <= bus.abort && (state_reg != S_IDLE);
            ring_en_reg     <= (state_next == S_RUN);
            counter_en_reg  <= (state_next == S_RUN);
            counter_rst_reg <= (state_next == S_LOAD);
        end
    end

    assign bus.busy               = busy_reg;
    assign bus.done               = done_reg;
    assign bus.aborted            = aborted_reg;
    assign bus.overflow           = overflow_reg;
    assign bus.result_sum         = result_sum_reg;
    assign bus.result_last        = result_last_reg;
    assign bus.a_input            = a_input_reg;
    assign bus.b_input            = b_input_reg;
    assign bus.a_input_ring_bit_b = ring_sel_reg;
    assign bus.a_input_ext_bit_b  = ext_sel_reg;
    assign bus.s_output_bit_b     = s_sel_reg;
    assign bus.ring_en            = ring_en_reg;
    assign bus.counter_en         = counter_en_reg;
    assign bus.counter_rst        = counter_rst_reg;
endmodule

// File: tb/tb_instrumented_adder_sequencer.sv
// Self-checking bench for instrumented_adder_sequencer: directed and random requests
// compared against request-level expectations (timing formulas, sums, selects).
module tb_instrumented_adder_sequencer;
    localparam int SETTLE = 4;

    logic wb_clk_i = 1'b0;
    logic wb_rst_i = 1'b1;
    always #5 wb_clk_i = ~wb_clk_i;

    instrumented_adder_sequencer_if #(.WIDTH(32), .SEL_W(5), .WIN_W(16), .CNT_W(32), .ACC_W(40)) bus ();
    instrumented_adder_sequencer_if #(.WIDTH(32), .SEL_W(5), .WIN_W(16), .CNT_W(32), .ACC_W(33)) bus33 ();

    instrumented_adder_sequencer #(
        .WIDTH(32), .SEL_W(5), .WIN_W(16), .CNT_W(32), .ACC_W(40), .SETTLE_CYCLES(SETTLE)
    ) dut (
        .wb_clk_i(wb_clk_i),
        .wb_rst_i(wb_rst_i),
        .bus     (bus)
    );

    instrumented_adder_sequencer #(
        .WIDTH(32), .SEL_W(5), .WIN_W(16), .CNT_W(32), .ACC_W(33), .SETTLE_CYCLES(SETTLE)
    ) dut33 (
        .wb_clk_i(wb_clk_i),
        .wb_rst_i(wb_rst_i),
        .bus     (bus33)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] counts[$];

    task automatic check(input string tag, input string name, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s: observed 0x%0h expected 0x%0h", tag, name, obs, exp);
        end
    endtask

    function automatic logic [31:0] sel_exp(input logic [4:0] idx);
        logic [31:0] v;
        v = '1;
        if (int'(idx) < 32) v[idx] = 1'b0;
        return v;
    endfunction

    // One request; counts[] supplies the ring count for each iteration in order.
    task automatic run_req(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rb, input logic [4:0] eb, input logic [4:0] sb,
                           input logic [15:0] win, input logic [7:0] rep,
                           input int abort_at, input bit abort_with_start);
        int w, r, per, exp_done, end_cyc, ncap, k;
        int ring_cnt, rst_cnt, overlap, done_cnt, done_cyc, busy_cnt, abort_cnt;
        int first_ring, last_ring;
        logic [63:0] true_sum, exp_last;
        w        = (win == 16'd0) ? 1 : int'(win);
        r        = (rep == 8'd0) ? 1 : int'(rep);
        per      = w + SETTLE + 3;
        exp_done = r * per + 1;
        end_cyc  = (abort_at > 0) ? abort_at + 1 : exp_done + 1;
        ncap     = 0;
        for (int i = 1; i <= r; i++) if (abort_at == 0 || i * per < abort_at) ncap++;
        true_sum = '0;
        exp_last = '0;
        for (int i = 0; i < ncap; i++) begin
            true_sum += 64'(counts[i]);
            exp_last  = 64'(counts[i]);
        end
        ring_cnt = 0; rst_cnt = 0; overlap = 0; done_cnt = 0; done_cyc = 0;
        busy_cnt = 0; abort_cnt = 0; first_ring = 0; last_ring = 0; k = 0;

        bus.req_a = a; bus.req_b = b;
        bus.req_ring_bit = rb; bus.req_ext_bit = eb; bus.req_s_bit = sb;
        bus.req_window = win; bus.req_repeats = rep;
        bus.start = 1'b1;
        bus.abort = abort_with_start;
        for (int cyc = 1; cyc <= end_cyc; cyc++) begin
            @(negedge wb_clk_i);
            if (cyc == 1) begin bus.start = 1'b0; bus.abort = 1'b0; end
            if (cyc == 2) begin
                // a start while busy, with altered fields, must change nothing
                bus.start = 1'b1; bus.req_a = ~a; bus.req_window = 16'd3;
                bus.req_repeats = 8'd9; bus.req_ring_bit = rb + 5'd1;
            end
            if (cyc == 3) bus.start = 1'b0;
            if (bus.ring_en) begin
                ring_cnt++;
                if (first_ring == 0) first_ring = cyc;
                last_ring = cyc;
            end
            if (bus.counter_rst) begin
                rst_cnt++;
                if (bus.ring_en) overlap++;
                if (k < counts.size()) bus.ring_count = counts[k];
                k++;
            end
            if (bus.done) begin done_cnt++; done_cyc = cyc; end
            if (bus.busy) busy_cnt++;
            if (bus.aborted) abort_cnt++;
            if (abort_at > 0 && cyc == abort_at) bus.abort = 1'b1;
            if (abort_at > 0 && cyc == abort_at + 1) begin
                check(tag, "aborted_pulse", 64'(bus.aborted), 64'd1);
                check(tag, "busy_after_abort", 64'(bus.busy), 64'd0);
                bus.abort = 1'b0;
            end
        end

        if (abort_at == 0) begin
            check(tag, "done_cycle", 64'(done_cyc), 64'(exp_done));
            check(tag, "busy_cycles", 64'(busy_cnt), 64'(exp_done));
            check(tag, "busy_after_done", 64'(bus.busy), 64'd0);
            check(tag, "ring_en_cycles", 64'(ring_cnt), 64'(r * w));
            check(tag, "first_ring", 64'(first_ring), 64'd3);
            check(tag, "last_ring", 64'(last_ring), 64'((r - 1) * per + w + 2));
            check(tag, "counter_rst_pulses", 64'(rst_cnt), 64'(r));
            check(tag, "abort_pulses", 64'(abort_cnt), 64'd0);
            check(tag, "a_input", 64'(bus.a_input), 64'(a));
            check(tag, "b_input", 64'(bus.b_input), 64'(b));
            check(tag, "ring_sel", 64'(bus.a_input_ring_bit_b), 64'(sel_exp(rb)));
            check(tag, "ext_sel", 64'(bus.a_input_ext_bit_b), 64'(sel_exp(eb)));
            check(tag, "s_sel", 64'(bus.s_output_bit_b), 64'(sel_exp(sb)));
        end else begin
            check(tag, "abort_pulses", 64'(abort_cnt), 64'd1);
            check(tag, "ring_en_after_abort", 64'(bus.ring_en), 64'd0);
        end
        check(tag, "done_pulses", 64'(done_cnt), (abort_at == 0) ? 64'd1 : 64'd0);
        check(tag, "rst_ring_overlap", 64'(overlap), 64'd0);
        check(tag, "result_sum", 64'(bus.result_sum), {24'd0, true_sum[39:0]});
        check(tag, "result_last", 64'(bus.result_last), exp_last);
        check(tag, "overflow", 64'(bus.overflow), (true_sum > 64'hFF_FFFF_FFFF) ? 64'd1 : 64'd0);
        $display("request %s: window=%0d repeats=%0d abort_at=%0d sum=0x%0h last=0x%0h",
                 tag, win, rep, abort_at, bus.result_sum, bus.result_last);
    endtask

    initial begin
        logic [31:0] ra, rb_op;
        bus.start = 1'b0; bus.abort = 1'b0; bus.req_a = '0; bus.req_b = '0;
        bus.req_ring_bit = '0; bus.req_ext_bit = '0; bus.req_s_bit = '0;
        bus.req_window = '0; bus.req_repeats = '0; bus.ring_count = '0;
        bus33.start = 1'b0; bus33.abort = 1'b0; bus33.req_a = '0; bus33.req_b = '0;
        bus33.req_ring_bit = '0; bus33.req_ext_bit = '0; bus33.req_s_bit = '0;
        bus33.req_window = '0; bus33.req_repeats = '0; bus33.ring_count = '0;

        // reset state
        wb_rst_i = 1'b1;
        repeat (2) @(negedge wb_clk_i);
        check("reset", "busy", 64'(bus.busy), 64'd0);
        check("reset", "done", 64'(bus.done), 64'd0);
        check("reset", "ring_en", 64'(bus.ring_en), 64'd0);
        check("reset", "ring_sel", 64'(bus.a_input_ring_bit_b), 64'hFFFF_FFFF);
        check("reset", "ext_sel", 64'(bus.a_input_ext_bit_b), 64'hFFFF_FFFF);
        check("reset", "s_sel", 64'(bus.s_output_bit_b), 64'hFFFF_FFFF);
        check("reset", "result_sum", 64'(bus.result_sum), 64'd0);
        check("reset", "a_input", 64'(bus.a_input), 64'd0);
        wb_rst_i = 1'b0;
        $display("reset: busy=%0d ring_sel=0x%0h", bus.busy, bus.a_input_ring_bit_b);

        // abort while idle does nothing
        bus.abort = 1'b1;
        @(negedge wb_clk_i);
        bus.abort = 1'b0;
        @(negedge wb_clk_i);
        check("idle_abort", "aborted", 64'(bus.aborted), 64'd0);
        check("idle_abort", "busy", 64'(bus.busy), 64'd0);
        $display("idle abort: aborted=%0d", bus.aborted);

        counts = {32'd1234};
        run_req("single", 32'h0000_FFFF, 32'd1, 5'd21, 5'd3, 5'd7, 16'd10, 8'd1, 0, 1'b0);
        check("single", "ring_sel_const", 64'(bus.a_input_ring_bit_b), 64'hFFDF_FFFF);

        counts = {32'd100, 32'd200, 32'd300};
        run_req("repeats", 32'h1234_5678, 32'h0BAD_F00D, 5'd0, 5'd31, 5'd16, 16'd5, 8'd3, 0, 1'b0);

        counts = {32'd77};
        run_req("zero_fields", 32'hFFFF_FFFF, 32'd0, 5'd1, 5'd2, 5'd30, 16'd0, 8'd0, 0, 1'b0);

        counts = {32'd55};
        run_req("abort", 32'hA5A5_A5A5, 32'h5A5A_5A5A, 5'd4, 5'd5, 5'd6, 16'd10, 8'd1, 5, 1'b0);
        counts = {32'd11, 32'd22};
        run_req("after_abort", 32'h0000_0001, 32'h0000_0002, 5'd9, 5'd10, 5'd11, 16'd2, 8'd2, 0, 1'b1);

        for (int t = 0; t < 6; t++) begin
            int nrep;
            logic [15:0] win;
            logic [7:0]  rep;
            ra    = $urandom;
            rb_op = $urandom;
            win   = 16'($urandom_range(0, 12));
            rep   = 8'($urandom_range(0, 4));
            nrep  = (rep == 8'd0) ? 1 : int'(rep);
            counts = {};
            for (int i = 0; i < nrep; i++) counts.push_back($urandom);
            run_req($sformatf("rand%0d", t), ra, rb_op, 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), win, rep, 0,
                    1'($urandom_range(0, 1)));
        end

        counts = {};
        for (int i = 0; i < 255; i++) counts.push_back(32'hFFFF_FFFF);
        run_req("big_sum", 32'd3, 32'd4, 5'd12, 5'd13, 5'd14, 16'd1, 8'd255, 0, 1'b0);
        check("big_sum", "sum_const", 64'(bus.result_sum), 64'h00FE_FFFF_FF01);
        counts = {32'd3, 32'd4};
        run_req("small_after_big", 32'd5, 32'd6, 5'd15, 5'd16, 5'd17, 16'd2, 8'd2, 0, 1'b0);

        // narrow accumulator: three full-scale counts carry out of 33 bits
        bus33.ring_count = 32'hFFFF_FFFF;
        bus33.req_window = 16'd1;
        bus33.req_repeats = 8'd3;
        bus33.start = 1'b1;
        @(negedge wb_clk_i);
        bus33.start = 1'b0;
        for (int i = 0; i < 100 && !bus33.done; i++) @(negedge wb_clk_i);
        check("acc33", "done_seen", 64'(bus33.done), 64'd1);
        check("acc33", "overflow", 64'(bus33.overflow), 64'd1);
        check("acc33", "result_sum", 64'(bus33.result_sum), 64'h0_FFFF_FFFD);
        $display("acc33: overflow=%0d sum=0x%0h", bus33.overflow, bus33.result_sum);
        @(negedge wb_clk_i);
        bus33.ring_count = 32'd5;
        bus33.req_repeats = 8'd1;
        bus33.start = 1'b1;
        @(negedge wb_clk_i);
        bus33.start = 1'b0;
        for (int i = 0; i < 100 && !bus33.done; i++) @(negedge wb_clk_i);
        check("acc33_next", "overflow", 64'(bus33.overflow), 64'd0);
        check("acc33_next", "result_sum", 64'(bus33.result_sum), 64'd5);
        $display("acc33 next: overflow=%0d sum=0x%0h", bus33.overflow, bus33.result_sum);

        // reset in the middle of a run beats a simultaneous abort
        bus.req_window = 16'd10; bus.req_repeats = 8'd1; bus.req_ring_bit = 5'd2;
        bus.start = 1'b1;
        @(negedge wb_clk_i);
        bus.start = 1'b0;
        repeat (4) @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        bus.abort = 1'b1;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        bus.abort = 1'b0;
        check("mid_reset", "busy", 64'(bus.busy), 64'd0);
        check("mid_reset", "aborted", 64'(bus.aborted), 64'd0);
        check("mid_reset", "ring_en", 64'(bus.ring_en), 64'd0);
        check("mid_reset", "ring_sel", 64'(bus.a_input_ring_bit_b), 64'hFFFF_FFFF);
        @(negedge wb_clk_i);
        check("mid_reset", "aborted_later", 64'(bus.aborted), 64'd0);
        $display("mid reset: busy=%0d aborted=%0d", bus.busy, bus.aborted);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
